// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: request/redirect bundle between pipeline stages and pipe_ctrl
interface pipe_ctrl_if #(parameter int STALL_W = 6, parameter int ADDR_W = 32, parameter int CNT_W = 32);
  logic               stallreq_id;
  logic               start_ex;
  logic               branch_flag_id;
  logic [ADDR_W-1:0]  branch_target_id;
  logic               exc_valid_mem;
  logic [ADDR_W-1:0]  exc_target_mem;
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  new_pc;
  logic               new_pc_valid;
  logic               done_ex;
  logic               busy;
  logic [CNT_W-1:0]   stall_cycles;
  modport master (output stallreq_id, start_ex, branch_flag_id, branch_target_id, exc_valid_mem, exc_target_mem,
                  input stall, flush, new_pc, new_pc_valid, done_ex, busy, stall_cycles);
  modport slave (input stallreq_id, start_ex, branch_flag_id, branch_target_id, exc_valid_mem, exc_target_mem,
                 output stall, flush, new_pc, new_pc_valid, done_ex, busy, stall_cycles);
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect sequencing for the 5-stage core with multi-cycle EX timing
module pipe_ctrl #(
  parameter int STALL_W    = 6,
  parameter int DIV_CYCLES = 32,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave b
);
  localparam int CW = 8;
  localparam logic [STALL_W-1:0] HOLD_EX = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] HOLD_ID = STALL_W'(6'b000111);
  typedef enum logic [1:0] {IDLE, MULTI, FLUSH} state_t;
  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic               done_q;
  logic [CNT_W-1:0]   sc;
  logic [STALL_W-1:0] stall;
  logic               flush, npc_v;
  logic [ADDR_W-1:0]  npc;
  // Outputs are forced to zero while reset is held, independent of inputs
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    stall = '0;
    flush = 1'b0;
    npc = '0;
    npc_v = 1'b0;
    if (rst) begin
      if (b.exc_valid_mem) begin
        flush = 1'b1;
        npc = b.exc_target_mem;
        npc_v = 1'b1;
        state_nx = FLUSH;
        cnt_nx = '0;
      end else if (state == FLUSH) begin
        state_nx = IDLE;
      end else if (state == MULTI) begin
        stall = HOLD_EX;
        cnt_nx = cnt - CW'(1);
        state_nx = cnt == CW'(1) ? IDLE : MULTI;
      end else if (b.start_ex) begin
        stall = HOLD_EX;
        cnt_nx = CW'(DIV_CYCLES - 1);
        state_nx = MULTI;
      end else if (b.stallreq_id) begin
        stall = HOLD_ID;
      end else if (b.branch_flag_id) begin
        npc = b.branch_target_id;
        npc_v = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      done_q <= 1'b0;
      sc <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      done_q <= state == MULTI && cnt == CW'(1) && !b.exc_valid_mem;
      if (|stall && !(&sc)) sc <= sc + CNT_W'(1);
    end
  end
  assign b.stall = stall;
  assign b.flush = flush;
  assign b.new_pc = npc;
  assign b.new_pc_valid = npc_v;
  assign b.done_ex = done_q;
  assign b.busy = state != IDLE;
  assign b.stall_cycles = sc;
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It arbitrates stall requests from ID (load-use) and EX (multi-cycle divide), flush requests from MEM (exceptions) and branch redirects from ID. It drives the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, the pipeline flush line, and the PC redirect. An internal FSM and counter time multi-cycle EX operations.

Parameters:
STALL_W, 6, stall vector width; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
DIV_CYCLES, 32, EX busy cycles per multi-cycle op, legal range 2..255
ADDR_W, 32, PC width
CNT_W, 32, stall statistics counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
stallreq_id  in  1  load-use hazard detected in ID
start_ex  in  1  one-cycle pulse: EX begins a multi-cycle op
branch_flag_id  in  1  ID resolved a taken branch/jump
branch_target_id  in  ADDR_W  taken target
exc_valid_mem  in  1  MEM raised an exception
exc_target_mem  in  ADDR_W  handler address
stall  out  STALL_W  per-stage hold, 1 = hold register
flush  out  1  clear all pipeline registers to zero
new_pc  out  ADDR_W  redirect address
new_pc_valid  out  1  pc_reg loads new_pc this cycle
done_ex  out  1  one-cycle pulse: multi-cycle result valid in EX
busy  out  1  FSM not in IDLE
stall_cycles  out  CNT_W  count of cycles with stall != 0, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, stall_cycles=0, done_ex=0. All combinational outputs then evaluate to 0.
- States: IDLE, MULTI, FLUSH. State, cnt, done_ex and stall_cycles are registered. stall, flush, new_pc and new_pc_valid are combinational from the current state and inputs, with zero latency.
- Priority per cycle: exc_valid_mem > MULTI/start_ex > stallreq_id > branch_flag_id.
- exc_valid_mem=1 in any state:
  - Outputs: flush=1, stall=0, new_pc=exc_target_mem, new_pc_valid=1.
  - Next state=FLUSH, cnt cleared. An in-flight multi-cycle op is aborted, and no done_ex is issued for it.
- FLUSH (exactly one cycle):
  - stall=0, flush=0, new_pc_valid=0. stallreq_id, start_ex and branch_flag_id are ignored because the stages hold bubbles.
  - Next state=IDLE unless exc_valid_mem=1 again, in which case FLUSH repeats with the new target.
- IDLE:
  - start_ex=1: stall=6'b001111. Load cnt=DIV_CYCLES-1 and go to MULTI.
  - Else stallreq_id=1: stall=6'b000111. EX receives a bubble through id_ex zeroing. No redirect, even if branch_flag_id=1; the branch is re-presented next cycle.
  - Else branch_flag_id=1: new_pc=branch_target_id, new_pc_valid=1, stall=0. There is no IF flush because of the architectural delay slot.
  - Else all outputs are 0.
- MULTI:
  - stall=6'b001111 every cycle and cnt decrements.
  - When cnt==1, the next cycle registers done_ex=1, state=IDLE, cnt=0. The total EX hold is DIV_CYCLES cycles, counted from the start_ex cycle inclusive.
  - stallreq_id and branch_flag_id are masked, since ID is held.
  - start_ex asserted while in MULTI is ignored, as a protocol error.
- done_ex is high for exactly one cycle, in the cycle after the last stalled cycle. stall is 0 in that cycle unless a new request arrives.
- stall_cycles increments on every clock where stall!=0 and saturates at all-ones.
- Reset mid-MULTI: immediate return to IDLE with no done_ex.

Test Plan:
- Reset: hold rst=0 with random inputs -> stall=0, flush=0, new_pc_valid=0, busy=0, stall_cycles=0. Release with idle inputs -> outputs stay 0.
- Load-use: pulse stallreq_id for 1 cycle -> stall=6'b000111 that cycle only. stall_cycles=1. Assert branch_flag_id in the same cycle -> new_pc_valid=0.
- Multi-cycle op with DIV_CYCLES=32: pulse start_ex at cycle T -> stall=6'b001111 for cycles T..T+31, done_ex=1 at T+32 only, busy=0 at T+32, stall_cycles=32.
- Exception aborts divide: start_ex at T, exc_valid_mem at T+5 with exc_target_mem=32'h00000020 -> at T+5 flush=1, stall=0, new_pc=32'h20, new_pc_valid=1. State is FLUSH at T+6 and IDLE at T+7. done_ex is never asserted.
- Branch: branch_flag_id=1 with target 32'h00400010 in IDLE -> new_pc_valid=1 and new_pc=32'h00400010 in the same cycle, stall=0.
- Saturation with CNT_W=4: hold stallreq_id for 20 cycles -> stall_cycles reaches 4'hF and holds there.
